// File: rtl/uart_rx_axis.sv
// 8N1 UART receiver presenting each byte on a one-entry AXI-stream master register.
// Define UART_RX_PARITY_EN to add an even-parity bit (11-bit frame) and the parity_err pulse.
module uart_rx_axis #(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_data,
  output logic [7:0] axis_tdata,
  output logic       axis_tvalid,
  input  logic       axis_tready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if (CLKS_PER_BIT < 4) begin : g_cpb_check
    $error("uart_rx_axis: CLKS_PER_BIT must be >= 4");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift_q;
  logic          rx_p0, rx_s;
  logic          done_p1;
  logic          good_p1;

  // Synchroniser stage: idle-high reset so a reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_p0 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_p0 <= rx_data;
      rx_s  <= rx_p0;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  assign good_p1 = done_p1 & ~par_bad;
`else
  assign good_p1 = done_p1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      frame_err <= 1'b0;
      done_p1   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad   <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      done_p1   <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          idx <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else cnt <= cnt + CNT_ONE;
        end
        DATA: begin
          if (cnt == CNT_MAX) begin
            cnt <= '0;
            idx <= idx + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (idx == 3'd7) state <= PARITY;
`else
            if (idx == 3'd7) state <= STOP;
`endif
          end else cnt <= cnt + CNT_ONE;
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == CNT_MAX) begin
            cnt     <= '0;
            par_bad <= ^{shift_q, rx_s};
            state   <= STOP;
          end else cnt <= cnt + CNT_ONE;
        end
`endif
        STOP: begin
          // Leave at mid stop bit so a back-to-back start edge is not missed
          if (cnt == CNT_MAX) begin
            cnt <= '0;
            if (rx_s) begin
              state   <= IDLE;
              done_p1 <= 1'b1;
            end else begin
              state     <= BREAK;
              frame_err <= 1'b1;
            end
          end else cnt <= cnt + CNT_ONE;
        end
        BREAK: begin
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == DATA && cnt == CNT_MAX) shift_q[idx] <= rx_s;
  end

  assign busy = (state != IDLE);

  // Output register stage: load when free or draining this cycle, otherwise drop as overrun
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      axis_tvalid <= 1'b0;
      axis_tdata  <= '0;
      overrun     <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (axis_tvalid && axis_tready) axis_tvalid <= 1'b0;
      if (good_p1) begin
        if (!axis_tvalid || axis_tready) begin
          axis_tdata  <= shift_q;
          axis_tvalid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) parity_err <= 1'b0;
    else        parity_err <= done_p1 & par_bad;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_axis.sv
// Scoreboard bench for uart_rx_axis: stimulus pushes expected bytes, a negedge monitor pops and compares.
module tb_uart_rx_axis;
  localparam int CLK_FREQ  = 160;
  localparam int BAUD_RATE = 10;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int LAT = 2 + 1 + CPB / 2 + (9 + PAR_BITS) * CPB + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_data = 1'b1;
  logic       axis_tready = 1'b0;
  logic [7:0] axis_tdata;
  logic       axis_tvalid, busy, frame_err, overrun, parity_err;

  uart_rx_axis #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data),
    .axis_tdata(axis_tdata), .axis_tvalid(axis_tvalid), .axis_tready(axis_tready),
    .busy(busy), .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, xfer_cnt = 0;
  int fall_cyc = 0, rise_cyc = -1, lat = 0;
  logic [7:0] exp_q[$];
  logic [7:0] e, held = '0;
  logic prev_valid = 1'b0, prev_stall = 1'b0;
  bit rand_rdy = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: pulse counting, handshake scoreboard and hold-stability
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (parity_err) pe_cnt++;
      if (frame_err || overrun) check("err_exclusive", int'(frame_err & overrun), 0);
      if (axis_tvalid && !prev_valid) rise_cyc = cyc;
      if (prev_stall) check("tdata_hold", axis_tdata, held);
      if (axis_tvalid && axis_tready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_xfer: got 0x%0h expected no transfer at cycle %0d", axis_tdata, cyc);
        end else begin
          e = exp_q.pop_front();
          check("xfer_data", axis_tdata, e);
        end
      end
      prev_stall = axis_tvalid && !axis_tready;
      held       = axis_tdata;
      prev_valid = axis_tvalid;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max && exp_q.size() != 0; i++) wait_cyc(1);
    check("drain_queue", exp_q.size(), 0);
  endtask

  // One frame on the line: start, 8 data LSB first, optional even parity (par_flip corrupts it), stop
  task automatic send(input logic [7:0] b, input logic stop, input logic par_flip, input logic chk_busy);
    logic [10:0] fr;
    int n;
    fr = '0;
    for (int i = 0; i < 8; i++) fr[i+1] = b[i];
    fr[9] = (^b) ^ par_flip;
    n = 9 + PAR_BITS;
    fr[n] = stop;
    n++;
    fall_cyc = cyc;
    for (int i = 0; i < n; i++) begin
      rx_data = fr[i];
      if (rand_rdy) axis_tready = 1'($urandom % 2);
      wait_cyc(CPB / 2);
      if (chk_busy) check("busy_in_frame", busy, 1);
      if (rand_rdy) axis_tready = 1'($urandom % 2);
      wait_cyc(CPB / 2);
    end
    rx_data = 1'b1;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] pat[4];
    int gap;
    pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h55; pat[3] = 8'hAA;

    // Reset state
    rst_n = 1'b0;
    wait_cyc(3);
    check("rst_tvalid", axis_tvalid, 0);
    check("rst_tdata", axis_tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_parity_err", parity_err, 0);
    rst_n = 1'b1;
    wait_cyc(4);

    // Single byte, latency and busy
    axis_tready = 1'b1;
    rise_cyc = -1;
    exp_q.push_back(8'h41);
    send(8'h41, 1'b1, 1'b0, 1'b1);
    wait_drain(40);
    lat = rise_cyc - fall_cyc;
    total++;
    if (lat < LAT - 1 || lat > LAT + 1) begin
      bad++;
      $display("FAIL latency: got %0d expected %0d +/-1", lat, LAT);
    end
    check("single_xfers", xfer_cnt, 1);
    check("single_fe", fe_cnt, 0);
    check("single_ov", ov_cnt, 0);
    check("single_pe", pe_cnt, 0);
    check("idle_busy", busy, 0);

    // Back-to-back frames, no idle gap
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(pat[i]);
      send(pat[i], 1'b1, 1'b0, 1'b0);
    end
    wait_drain(40);
    check("b2b_xfers", xfer_cnt, 5);

    // Overrun: second byte dropped while first is held
    axis_tready = 1'b0;
    exp_q.push_back(8'h12);
    send(8'h12, 1'b1, 1'b0, 1'b0);
    send(8'h34, 1'b1, 1'b0, 1'b0);
    wait_cyc(6);
    check("ovr_tvalid", axis_tvalid, 1);
    check("ovr_tdata", axis_tdata, 8'h12);
    check("ovr_count", ov_cnt, 1);
    axis_tready = 1'b1;
    wait_drain(10);
    wait_cyc(20);
    check("ovr_xfers", xfer_cnt, 6);
    check("ovr_count_after", ov_cnt, 1);

    // Framing error followed by a long break, then a clean frame
    send(8'h5A, 1'b0, 1'b0, 1'b0);
    rx_data = 1'b0;
    wait_cyc(40 * CPB);
    check("break_busy", busy, 1);
    check("break_fe", fe_cnt, 1);
    check("break_xfers", xfer_cnt, 6);
    rx_data = 1'b1;
    wait_cyc(2 * CPB);
    check("break_release_busy", busy, 0);
    exp_q.push_back(8'h66);
    send(8'h66, 1'b1, 1'b0, 1'b0);
    wait_drain(40);
    check("after_break_xfers", xfer_cnt, 7);
    check("after_break_fe", fe_cnt, 1);

    // Short glitch on the idle line
    rx_data = 1'b0;
    wait_cyc(3);
    rx_data = 1'b1;
    wait_cyc(4);
    check("glitch_busy_start", busy, 1);
    wait_cyc(CPB);
    check("glitch_busy_end", busy, 0);
    check("glitch_xfers", xfer_cnt, 7);
    check("glitch_fe", fe_cnt, 0 + 1);

    // Reset during data bit 4 discards the frame
    fork
      send(8'hF7, 1'b1, 1'b0, 1'b0);
      begin
        wait_cyc(5 * CPB + CPB / 2);
        rst_n = 1'b0;
        wait_cyc(1);
        check("midrst_tvalid", axis_tvalid, 0);
        check("midrst_tdata", axis_tdata, 0);
        check("midrst_busy", busy, 0);
        check("midrst_fe", frame_err, 0);
        check("midrst_ov", overrun, 0);
        rst_n = 1'b1;
      end
    join
    wait_cyc(2 * CPB);
    check("midrst_xfers", xfer_cnt, 7);
    check("midrst_busy_after", busy, 0);

`ifdef UART_RX_PARITY_EN
    // Good parity delivered, bad parity dropped with a pulse
    exp_q.push_back(8'h07);
    send(8'h07, 1'b1, 1'b0, 1'b0);
    send(8'h07, 1'b1, 1'b1, 1'b0);
    wait_drain(40);
    wait_cyc(10);
    check("parity_pe", pe_cnt, 1);
    check("parity_xfers", xfer_cnt, 8);
`endif

    // Randomized bytes, gaps and ready pattern
    rand_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send(b, 1'b1, 1'b0, 1'b0);
      axis_tready = 1'b1;
      gap = int'($urandom_range(0, 20));
      if (gap > 0) wait_cyc(gap);
    end
    rand_rdy = 1'b0;
    axis_tready = 1'b1;
    wait_drain(60);
    check("rand_xfers", xfer_cnt, 7 + PAR_BITS + 12);
    check("rand_ov", ov_cnt, 1);
    check("rand_fe", fe_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
